// File: rtl/elm_weight_loader.sv
// elm_weight_loader: streams one layer's bias + weight words into its neurons.
// Optional `BIAS_SELECT_EN adds a one-hot per-neuron bias strobe vector.
module elm_weight_loader #(
    parameter int layerNo    = 1,
    parameter int numNeurons = 64,
    parameter int numWeight  = 128,
    parameter int dataWidth  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [dataWidth-1:0]   s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    output logic [dataWidth-1:0]   weightValue,
    output logic                   weightValid,
    output logic [dataWidth-1:0]   biasValue,
    output logic                   biasValid,
    output logic [2*dataWidth:0]   config_layer_num,
    output logic [2*dataWidth:0]   config_neuron_num,
`ifdef BIAS_SELECT_EN
    output logic [numNeurons-1:0]  bias_valid_vec,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CW = 2*dataWidth+1;
    localparam int NW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam int WW = (numWeight > 1) ? $clog2(numWeight) : 1;

    localparam logic [NW-1:0] N_LAST = NW'(numNeurons-1);
    localparam logic [WW-1:0] W_LAST = WW'(numWeight-1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIAS = 2'd1;
    localparam logic [1:0] S_WGT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [NW-1:0] n_cnt;
    logic [WW-1:0] w_cnt;
    logic          beat;
    logic          go;
    logic          last_beat;
    logic          frame_bad;

    assign beat      = s_valid & s_ready;
    assign go        = (state == S_IDLE) & start;
    assign last_beat = (state == S_WGT) & (n_cnt == N_LAST) & (w_cnt == W_LAST);
    assign frame_bad = beat & (s_last != last_beat);

    // Next-state decode; counting never looks at s_last.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start) state_nx = S_BIAS;
            S_BIAS: if (beat) state_nx = S_WGT;
            S_WGT: begin
                if (beat && (w_cnt == W_LAST))
                    state_nx = (n_cnt == N_LAST) ? S_DONE : S_BIAS;
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register plus neuron / word position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            n_cnt <= '0;
            w_cnt <= '0;
        end else begin
            state <= state_nx;
            if (go) begin
                n_cnt <= '0;
                w_cnt <= '0;
            end else if (beat && (state == S_WGT)) begin
                if (w_cnt == W_LAST) begin
                    w_cnt <= '0;
                    if (n_cnt != N_LAST)
                        n_cnt <= n_cnt + 1'b1;
                end else begin
                    w_cnt <= w_cnt + 1'b1;
                end
            end
        end
    end

    // Registered status decodes of the next state, plus sticky framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            config_layer_num <= '0;
        end else begin
            s_ready <= (state_nx == S_BIAS) | (state_nx == S_WGT);
            busy    <= (state_nx != S_IDLE);
            done    <= (state == S_DONE);
            if (state_nx != S_IDLE)
                config_layer_num <= CW'(layerNo);
            else
                config_layer_num <= '0;
            if (go)
                err <= 1'b0;
            else if (frame_bad)
                err <= 1'b1;
        end
    end

    // Neuron-side load bus: strobe, word and neuron index move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            biasValid         <= 1'b0;
            weightValid       <= 1'b0;
            biasValue         <= '0;
            weightValue       <= '0;
            config_neuron_num <= '0;
        end else begin
            biasValid   <= beat & (state == S_BIAS);
            weightValid <= beat & (state == S_WGT);
            if (go)
                config_neuron_num <= '0;
            else if (beat)
                config_neuron_num <= CW'(n_cnt);
            if (beat && (state == S_BIAS))
                biasValue <= s_data;
            if (beat && (state == S_WGT))
                weightValue <= s_data;
        end
    end

`ifdef BIAS_SELECT_EN
    // One-hot bias select, aligned with biasValid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_valid_vec <= '0;
        end else begin
            bias_valid_vec <= '0;
            if (beat && (state == S_BIAS))
                bias_valid_vec[n_cnt] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_elm_weight_loader.sv
// tb_elm_weight_loader: table vectors, directed corner sequences and random
// stimulus checked every cycle against a beat-index reference model.
module tb_elm_weight_loader;

    localparam int NN    = 2;
    localparam int NWT   = 4;
    localparam int DW    = 16;
    localparam int TOTAL = NN*(NWT+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [DW-1:0] weightValue;
    logic          weightValid;
    logic [DW-1:0] biasValue;
    logic          biasValid;
    logic [2*DW:0] config_layer_num;
    logic [2*DW:0] config_neuron_num;
    logic          busy;
    logic          done;
    logic          err;
`ifdef BIAS_SELECT_EN
    logic [NN-1:0] bias_valid_vec;
`endif

    elm_weight_loader #(
        .layerNo(1), .numNeurons(NN), .numWeight(NWT), .dataWidth(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last),
        .weightValue(weightValue), .weightValid(weightValid),
        .biasValue(biasValue), .biasValid(biasValid),
        .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num),
`ifdef BIAS_SELECT_EN
        .bias_valid_vec(bias_valid_vec),
`endif
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int cmp_n = 0;
    int bad_n = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        cmp_n++;
        if (a !== e) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Reference model: position is a flat beat index into the layer stream.
    bit            m_act = 0, m_fin = 0, m_err = 0;
    int            m_cnt = 0, mn, mp;
    bit            m_lst;
    logic          e_ready = 0, e_busy = 0, e_done = 0, e_bv = 0, e_wv = 0;
    logic [DW-1:0] e_bval = '0, e_wval = '0;
    logic [2*DW:0] e_layer = '0, e_nn = '0;
    logic [NN-1:0] e_vec = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_fin = 0; m_err = 0; m_cnt = 0;
            e_ready = 0; e_busy = 0; e_done = 0; e_bv = 0; e_wv = 0;
            e_bval = '0; e_wval = '0; e_layer = '0; e_nn = '0; e_vec = '0;
        end else begin
            e_bv = 0; e_wv = 0; e_done = 0; e_vec = '0;
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_fin = 0; m_cnt = 0; m_err = 0; e_nn = '0;
                end
            end else if (m_fin) begin
                e_done = 1; m_act = 0; m_fin = 0;
            end else if (s_valid) begin
                mn = m_cnt / (NWT+1);
                mp = m_cnt % (NWT+1);
                m_lst = (m_cnt == TOTAL-1);
                if (mp == 0) begin
                    e_bv = 1; e_bval = s_data; e_vec[mn] = 1'b1;
                end else begin
                    e_wv = 1; e_wval = s_data;
                end
                e_nn = (2*DW+1)'(mn);
                if (s_last != m_lst) m_err = 1;
                m_cnt++;
                if (m_lst) m_fin = 1;
            end
            e_ready = m_act && !m_fin;
            e_busy  = m_act;
            e_layer = m_act ? 33'd1 : 33'd0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", s_ready, e_ready);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, m_err);
            chk("biasValid", biasValid, e_bv);
            chk("weightValid", weightValid, e_wv);
            chk("biasValue", biasValue, e_bval);
            chk("weightValue", weightValue, e_wval);
            chk("layer_num", config_layer_num, e_layer);
            chk("neuron_num", config_neuron_num, e_nn);
`ifdef BIAS_SELECT_EN
            chk("bias_vec", bias_valid_vec, e_vec);
`endif
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        bit            is_bias;
        int            neuron;
    } vec_t;

    vec_t tv[10];
    int   st = 0;
    int   lat;
    int   k;
    bit   seen;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        st = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int j = 0; j < 40; j++) begin
            if (done) begin
                l = cyc - st;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{16'd1,  1'b0, 1'b1, 0};
        tv[1] = '{16'd2,  1'b0, 1'b0, 0};
        tv[2] = '{16'd3,  1'b0, 1'b0, 0};
        tv[3] = '{16'd4,  1'b0, 1'b0, 0};
        tv[4] = '{16'd5,  1'b0, 1'b0, 0};
        tv[5] = '{16'd6,  1'b0, 1'b1, 1};
        tv[6] = '{16'd7,  1'b0, 1'b0, 1};
        tv[7] = '{16'd8,  1'b0, 1'b0, 1};
        tv[8] = '{16'd9,  1'b0, 1'b0, 1};
        tv[9] = '{16'd10, 1'b1, 1'b0, 1};

        #1 rst_n = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_layer", config_layer_num, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Continuous stream, table-driven.
        do_start();
        for (int i = 0; i < 10; i++) begin
            send(tv[i].data, tv[i].last);
            chk("t1_bv", biasValid, tv[i].is_bias);
            chk("t1_wv", weightValid, !tv[i].is_bias);
            chk("t1_val", tv[i].is_bias ? biasValue : weightValue, tv[i].data);
            chk("t1_nn", config_neuron_num, tv[i].neuron);
        end
        idle();
        wait_done(lat);
        chk("t1_done_lat", lat, 12);
        chk("t1_err", err, 0);
        tick();

        // s_valid toggling 1/0.
        do_start();
        for (int i = 0; i < 10; i++) begin
            send(tv[i].data, tv[i].last);
            idle();
            tick();
        end
        wait_done(lat);
        chk("t2_done_lat", lat, 21);
        tick();

        // s_last on word 5: sticky err, load still completes.
        do_start();
        for (int i = 0; i < 10; i++) begin
            send(tv[i].data, i == 4);
            if (i == 3) chk("t3_err_pre", err, 0);
            if (i == 4) chk("t3_err_set", err, 1);
        end
        idle();
        wait_done(lat);
        chk("t3_done_lat", lat, 12);
        chk("t3_err_hold", err, 1);
        tick();
        do_start();
        chk("t3_err_clr", err, 0);
        for (int i = 0; i < 10; i++) send(tv[i].data, tv[i].last);
        idle();
        wait_done(lat);
        chk("t3b_err", err, 0);
        tick();

        // Reset mid-load after word 3.
        do_start();
        for (int i = 0; i < 3; i++) send(tv[i].data, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("t4_s_ready", s_ready, 0);
        chk("t4_busy", busy, 0);
        chk("t4_wv", weightValid, 0);
        chk("t4_wval", weightValue, 0);
        chk("t4_nn", config_neuron_num, 0);
        chk("t4_layer", config_layer_num, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        send(16'd4, 1'b0);
        chk("t4_bv", biasValid, 1);
        chk("t4_bval", biasValue, 4);
        chk("t4_nn0", config_neuron_num, 0);
        for (int i = 5; i <= 13; i++) send(i[DW-1:0], i == 13);
        idle();
        wait_done(lat);
        chk("t4_done_lat", lat, 12);
        tick();

        // start pulsed mid-load is ignored.
        do_start();
        for (int i = 0; i < 10; i++) begin
            start = (i == 2) || (i == 6);
            send(tv[i].data, tv[i].last);
            if (i == 2) chk("t5_nn", config_neuron_num, 0);
            if (i == 6) chk("t5_wval", weightValue, 7);
        end
        start = 1'b0;
        idle();
        wait_done(lat);
        chk("t5_done_lat", lat, 12);
        tick();

        // Randomized loads.
        for (int l = 0; l < 8; l++) begin
            do_start();
            seen = 1'b0;
            k = 0;
            while (m_act && k < 200) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = DW'($urandom);
                s_last  = (m_cnt == TOTAL-1) ^ ($urandom_range(0, 11) == 0);
                start   = ($urandom_range(0, 9) == 0);
                tick();
                if (done) seen = 1'b1;
                k++;
            end
            start = 1'b0;
            idle();
            chk("rand_done", seen, 1);
            repeat ($urandom_range(1, 3)) tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
